// File: rtl/ring_buffer_pkg.sv
// ring_buffer_pkg: shared types and constants for the scope capture ring buffer.
//   RB_ADDR_W     - default address/depth width
//   rb_addr_t     - address type of that width
//   RB_WRAP_CNT_W - width of the optional saturating wrap counter
package ring_buffer_pkg;

    localparam int unsigned RB_ADDR_W     = 29;
    localparam int unsigned RB_WRAP_CNT_W = 16;

    typedef logic [RB_ADDR_W-1:0] rb_addr_t;

endpackage : ring_buffer_pkg

// File: rtl/ring_buffer_wrap_counter.sv
// ring_buffer_wrap_counter: saturating count of ring buffer wraps.
// Only instantiated when RING_BUFFER_ADDRESS_WRAP_CNT_EN is defined.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset, clears the count
//   inc_i - one wrap event this cycle
//   cnt_o - registered wrap count, sticks at all-ones
module ring_buffer_wrap_counter
    import ring_buffer_pkg::*;
#(
    parameter int unsigned CntW = RB_WRAP_CNT_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    output logic [CntW-1:0] cnt_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // Saturate rather than roll over so software never sees a small count after many passes
        if (inc_i && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : ring_buffer_wrap_counter

// File: rtl/ring_buffer_address.sv
// ring_buffer_address: free-running circular write-address generator for the
// scope capture sample RAM. Steps 0..D-1 while enabled and wraps to 0, where
// D = depth (depth = 0 is treated as D = 1).
// Ports:
//   clk      - sole clock, rising edge
//   rstn     - synchronous reset, ACTIVE HIGH despite the name (1 = reset)
//   en       - advance enable
//   depth    - buffer size, sampled every cycle
//   addr     - registered write address
//   wrap     - registered one-cycle pulse coincident with addr returning to 0
//   full     - sticky, set by the first wrap, cleared only by reset
//   wrap_cnt - saturating wrap count (only with RING_BUFFER_ADDRESS_WRAP_CNT_EN)
// Optional feature macro: RING_BUFFER_ADDRESS_WRAP_CNT_EN
module ring_buffer_address
    import ring_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = RB_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic [ADDR_W-1:0]        depth,
    output logic [ADDR_W-1:0]        addr,
    output logic                     wrap,
`ifdef RING_BUFFER_ADDRESS_WRAP_CNT_EN
    output logic                     full,
    output logic [RB_WRAP_CNT_W-1:0] wrap_cnt
`else
    output logic                     full
`endif
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              full_q, full_d;
    logic [ADDR_W-1:0] last_addr;
    logic              wrap_evt;

    // Last valid address D-1; depth 0 behaves as a single-entry buffer
    assign last_addr = (depth == '0) ? '0 : (depth - ADDR_W'(1));

    // >= rather than == so a depth lowered below the current address wraps at once
    assign wrap_evt = en && (addr_q >= last_addr);

    always_comb begin
        addr_d = addr_q;
        wrap_d = 1'b0;
        full_d = full_q;
        if (en) begin
            if (wrap_evt) begin
                addr_d = '0;
                wrap_d = 1'b1;
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
            full_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wrap_q <= wrap_d;
            full_q <= full_d;
        end
    end

    assign addr = addr_q;
    assign wrap = wrap_q;
    assign full = full_q;

`ifdef RING_BUFFER_ADDRESS_WRAP_CNT_EN
    ring_buffer_wrap_counter #(
        .CntW (RB_WRAP_CNT_W)
    ) u_wrap_counter (
        .clk_i (clk),
        .rst_i (rstn),
        .inc_i (wrap_evt),
        .cnt_o (wrap_cnt)
    );
`endif

endmodule : ring_buffer_address

// File: tb/tb_ring_buffer_address.sv
// tb_ring_buffer_address: directed self-checking bench for ring_buffer_address.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ring_buffer_address;

    localparam int unsigned AW = 29;

    logic          clk;
    logic          rstn;
    logic          en;
    logic [AW-1:0] depth;
    logic [AW-1:0] addr;
    logic          wrap;
    logic          full;
`ifdef RING_BUFFER_ADDRESS_WRAP_CNT_EN
    logic [15:0]   wrap_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ring_buffer_address #(
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .depth    (depth),
        .addr     (addr),
        .wrap     (wrap),
`ifdef RING_BUFFER_ADDRESS_WRAP_CNT_EN
        .full     (full),
        .wrap_cnt (wrap_cnt)
`else
        .full     (full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        step();
        rstn = 1'b0;
    endtask

    task automatic check_out(input string tag, input int unsigned a, input bit w, input bit f);
        check_eq({tag, ".addr"}, 32'(addr), 32'(a));
        check_eq({tag, ".wrap"}, 32'(wrap), 32'(w));
        check_eq({tag, ".full"}, 32'(full), 32'(f));
    endtask

    initial begin
        int unsigned seq_a[4];
        bit          seq_w[4];
        bit          seq_en[4];
        int unsigned exp_a;

        rstn  = 1'b1;
        en    = 1'b0;
        depth = AW'(16);
        step();
        step();
        check_out("reset", 0, 1'b0, 1'b0);

        // en low after reset: everything holds at 0
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("idle", 0, 1'b0, 1'b0);
        end

        // Long run at depth 16400: wraps at enabled edges 16400 and 32800
        depth = AW'(16400);
        en    = 1'b1;
        for (int i = 1; i <= 34000; i++) begin
            step();
            exp_a = i % 16400;
            check_out("long", exp_a, (exp_a == 0), (i >= 16400));
        end
        check_eq("long.end_addr", 32'(addr), 32'd1200);
`ifdef RING_BUFFER_ADDRESS_WRAP_CNT_EN
        check_eq("long.wrap_cnt", 32'(wrap_cnt), 32'd2);
`endif

        // Depth lowered below the current address
        en = 1'b0;
        do_reset();
        depth = AW'(8);
        en    = 1'b1;
        for (int i = 1; i <= 6; i++) step();
        check_out("lower.pre", 6, 1'b0, 1'b0);
        depth = AW'(4);
        step();
        check_out("lower.wrap", 0, 1'b1, 1'b1);
        seq_a = '{1, 2, 3, 0};
        seq_w = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("lower.seq", seq_a[i], seq_w[i], 1'b1);
        end

        // depth 0 and depth 1 both behave as D=1
        do_reset();
        depth = AW'(0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("depth0", 0, 1'b1, 1'b1);
        end
        do_reset();
        depth = AW'(1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("depth1", 0, 1'b1, 1'b1);
        end

        // Enable toggling
        en = 1'b0;
        do_reset();
        depth  = AW'(10);
        seq_en = '{1'b1, 1'b0, 1'b1, 1'b0};
        seq_a  = '{1, 1, 2, 2};
        for (int i = 0; i < 4; i++) begin
            en = seq_en[i];
            step();
            check_out("toggle", seq_a[i], 1'b0, 1'b0);
        end

        // Get full=1 and addr=5: wrap at depth 4, then count up at depth 10
        en    = 1'b1;
        depth = AW'(4);
        step();
        check_out("prep.a3", 3, 1'b0, 1'b0);
        step();
        check_out("prep.wrap", 0, 1'b1, 1'b1);
        depth = AW'(10);
        for (int i = 1; i <= 5; i++) step();
        check_out("prep.a5", 5, 1'b0, 1'b1);

        // Reset dominates en
        rstn = 1'b1;
        step();
        check_out("midreset", 0, 1'b0, 1'b0);
`ifdef RING_BUFFER_ADDRESS_WRAP_CNT_EN
        check_eq("midreset.wrap_cnt", 32'(wrap_cnt), 32'd0);
`endif
        rstn = 1'b0;
        step();
        check_out("postreset", 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ring_buffer_address
